// File: rtl/ex_stage_if.sv
// Execute-stage bundle: ID/EX entry and decoder controls in, registered EX/WB
// results and condition codes out.
interface ex_stage_if #(
  parameter int unsigned DW = 8
);
  logic          in_valid;
  logic          stall;
  logic          flush;
  logic [3:0]    alu_control;
  logic          se2;
  logic [1:0]    se3;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic          flag_we;
  logic [1:0]    rd_in;
  logic          wb_in;
  logic          int_save;
  logic          int_restore;
  logic          ex_valid;
  logic [DW-1:0] ex_result;
  logic [1:0]    ex_rd;
  logic          ex_wb;
  logic [3:0]    ccr;
  logic [3:0]    ccr_shadow;

  modport master (
    output in_valid, stall, flush, alu_control, se2, se3, op_a, op_b, flag_we,
           rd_in, wb_in, int_save, int_restore,
    input  ex_valid, ex_result, ex_rd, ex_wb, ccr, ccr_shadow
  );

  modport slave (
    input  in_valid, stall, flush, alu_control, se2, se3, op_a, op_b, flag_we,
           rd_in, wb_in, int_save, int_restore,
    output ex_valid, ex_result, ex_rd, ex_wb, ccr, ccr_shadow
  );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: ALU, result select and EX/WB register, plus the {V,C,N,Z}
// condition-code register with a one-deep interrupt shadow copy.
module ex_stage #(
  parameter int unsigned DW = 8
) (
  input logic         clk,
  input logic         rst,
  ex_stage_if.slave   bus
);
  localparam logic [3:0] OpAdd  = 4'h2;
  localparam logic [3:0] OpSub  = 4'h3;
  localparam logic [3:0] OpAnd  = 4'h4;
  localparam logic [3:0] OpOr   = 4'h5;
  localparam logic [3:0] OpRlc  = 4'h6;
  localparam logic [3:0] OpRrc  = 4'h7;
  localparam logic [3:0] OpSetc = 4'h8;
  localparam logic [3:0] OpClrc = 4'h9;
  localparam logic [3:0] OpNot  = 4'hA;
  localparam logic [3:0] OpNeg  = 4'hB;
  localparam logic [3:0] OpInc  = 4'hC;
  localparam logic [3:0] OpDec  = 4'hD;
  localparam logic [DW-1:0] MsbOnly = {1'b1, {(DW-1){1'b0}}};

  logic          valid_q, wb_q;
  logic [DW-1:0] result_q, result_d;
  logic [1:0]    rd_q;
  logic [3:0]    ccr_q, ccr_d, shadow_q;

  logic [DW-1:0] a, b, alu_res;
  logic [DW:0]   ext;
  logic          c_n, v_n, zn_we, flag_op, flag_upd;

  always_comb begin
    a       = bus.op_a;
    b       = bus.se2 ? DW'(1) : bus.op_b;
    alu_res = '0;
    ext     = '0;
    c_n     = ccr_q[2];
    v_n     = ccr_q[3];
    zn_we   = 1'b0;
    flag_op = 1'b1;
    case (bus.alu_control)
      OpAdd: begin
        ext     = {1'b0, a} + {1'b0, b};
        alu_res = ext[DW-1:0];
        c_n     = ext[DW];
        v_n     = (a[DW-1] == b[DW-1]) && (alu_res[DW-1] != a[DW-1]);
        zn_we   = 1'b1;
      end
      OpSub: begin
        alu_res = a - b;
        c_n     = a < b;
        v_n     = (a[DW-1] != b[DW-1]) && (alu_res[DW-1] != a[DW-1]);
        zn_we   = 1'b1;
      end
      OpAnd: begin alu_res = a & b; zn_we = 1'b1; end
      OpOr:  begin alu_res = a | b; zn_we = 1'b1; end
      // Rotates take carry-in from the registered flag, not this cycle's result.
      OpRlc: begin alu_res = {b[DW-2:0], ccr_q[2]}; c_n = b[DW-1]; zn_we = 1'b1; end
      OpRrc: begin alu_res = {ccr_q[2], b[DW-1:1]}; c_n = b[0];    zn_we = 1'b1; end
      OpSetc: c_n = 1'b1;
      OpClrc: c_n = 1'b0;
      OpNot: begin alu_res = ~b; zn_we = 1'b1; end
      OpNeg: begin
        alu_res = '0 - b;
        c_n     = b != '0;
        v_n     = b == MsbOnly;
        zn_we   = 1'b1;
      end
      OpInc: begin
        ext     = {1'b0, b} + {{DW{1'b0}}, 1'b1};
        alu_res = ext[DW-1:0];
        c_n     = ext[DW];
        v_n     = ~b[DW-1] & alu_res[DW-1];
        zn_we   = 1'b1;
      end
      OpDec: begin
        alu_res = b - DW'(1);
        c_n     = b == '0;
        v_n     = b[DW-1] & ~alu_res[DW-1];
        zn_we   = 1'b1;
      end
      default: flag_op = 1'b0;
    endcase

    ccr_d = {v_n, c_n,
             zn_we ? alu_res[DW-1]    : ccr_q[1],
             zn_we ? (alu_res == '0)  : ccr_q[0]};

    unique case (bus.se3)
      2'd0: result_d = alu_res;
      2'd1: result_d = bus.op_a;
      2'd2: result_d = bus.op_b;
      default: result_d = '0;
    endcase

    flag_upd = bus.in_valid & bus.flag_we & ~bus.stall & ~bus.flush & flag_op;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      rd_q     <= '0;
      wb_q     <= 1'b0;
      ccr_q    <= '0;
      shadow_q <= '0;
    end else begin
      if (bus.flush) begin
        valid_q  <= 1'b0;
        wb_q     <= 1'b0;
        result_q <= result_d;
        rd_q     <= bus.rd_in;
      end else if (!bus.stall) begin
        valid_q  <= bus.in_valid;
        wb_q     <= bus.wb_in;
        result_q <= result_d;
        rd_q     <= bus.rd_in;
      end

      // A simultaneous save and restore is a restore from the old shadow.
      if (bus.int_save && !bus.int_restore) begin
        shadow_q <= ccr_q;
      end

      if (bus.int_restore && (!bus.stall || bus.flush)) begin
        ccr_q <= shadow_q;
      end else if (flag_upd) begin
        ccr_q <= ccr_d;
      end
    end
  end

  assign bus.ex_valid   = valid_q;
  assign bus.ex_result  = result_q;
  assign bus.ex_rd      = rd_q;
  assign bus.ex_wb      = wb_q;
  assign bus.ccr        = ccr_q;
  assign bus.ccr_shadow = shadow_q;
endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: a chained vector table of ALU operations with
// hand-computed results and flags, then interrupt, stall, flush and reset sequences.
module tb_ex_stage;
  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  ex_stage_if #(.DW(8)) bus ();

  ex_stage #(.DW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] alu;
    logic       se2;
    logic [1:0] se3;
    logic [7:0] a;
    logic [7:0] b;
    logic       fw;
    logic       vld;
    logic [7:0] exp_res;
    logic [3:0] exp_ccr;
  } vec_t;

  vec_t vecs[25];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] alu, input logic se2, input logic [1:0] se3,
                       input logic [7:0] a, input logic [7:0] b, input logic fw,
                       input logic vld);
    bus.alu_control = alu;
    bus.se2         = se2;
    bus.se3         = se3;
    bus.op_a        = a;
    bus.op_b        = b;
    bus.flag_we     = fw;
    bus.in_valid    = vld;
  endtask

  initial begin
    // {alu, se2, se3, a, b, flag_we, in_valid, result, ccr}; ccr chains from 0.
    vecs[0]  = '{4'h2, 1'b0, 2'd0, 8'h7F, 8'h01, 1'b1, 1'b1, 8'h80, 4'hA};
    vecs[1]  = '{4'h8, 1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h00, 4'hE};
    vecs[2]  = '{4'h6, 1'b0, 2'd0, 8'h00, 8'h80, 1'b1, 1'b1, 8'h01, 4'hC};
    vecs[3]  = '{4'h7, 1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h80, 4'hA};
    vecs[4]  = '{4'h3, 1'b1, 2'd0, 8'h03, 8'h55, 1'b1, 1'b1, 8'h02, 4'h0};
    vecs[5]  = '{4'h3, 1'b1, 2'd0, 8'h01, 8'h55, 1'b1, 1'b1, 8'h00, 4'h1};
    vecs[6]  = '{4'h2, 1'b1, 2'd0, 8'h41, 8'h99, 1'b0, 1'b1, 8'h42, 4'h1};
    vecs[7]  = '{4'h3, 1'b0, 2'd0, 8'h00, 8'h01, 1'b1, 1'b1, 8'hFF, 4'h6};
    vecs[8]  = '{4'h4, 1'b0, 2'd0, 8'hF0, 8'h3C, 1'b1, 1'b1, 8'h30, 4'h4};
    vecs[9]  = '{4'h5, 1'b0, 2'd0, 8'h00, 8'h80, 1'b1, 1'b1, 8'h80, 4'h6};
    vecs[10] = '{4'hA, 1'b0, 2'd0, 8'h00, 8'hFF, 1'b1, 1'b1, 8'h00, 4'h5};
    vecs[11] = '{4'hB, 1'b0, 2'd0, 8'h00, 8'h80, 1'b1, 1'b1, 8'h80, 4'hE};
    vecs[12] = '{4'hB, 1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h00, 4'h1};
    vecs[13] = '{4'hC, 1'b0, 2'd0, 8'h00, 8'hFF, 1'b1, 1'b1, 8'h00, 4'h5};
    vecs[14] = '{4'hC, 1'b0, 2'd0, 8'h00, 8'h7F, 1'b1, 1'b1, 8'h80, 4'hA};
    vecs[15] = '{4'hD, 1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 4'h6};
    vecs[16] = '{4'hD, 1'b0, 2'd0, 8'h00, 8'h80, 1'b1, 1'b1, 8'h7F, 4'h8};
    vecs[17] = '{4'h8, 1'b0, 2'd0, 8'h12, 8'h34, 1'b1, 1'b1, 8'h00, 4'hC};
    vecs[18] = '{4'h9, 1'b0, 2'd0, 8'h12, 8'h34, 1'b1, 1'b1, 8'h00, 4'h8};
    vecs[19] = '{4'h2, 1'b0, 2'd1, 8'h55, 8'hAA, 1'b0, 1'b1, 8'h55, 4'h8};
    vecs[20] = '{4'h2, 1'b0, 2'd2, 8'h55, 8'hAA, 1'b0, 1'b1, 8'hAA, 4'h8};
    vecs[21] = '{4'h2, 1'b0, 2'd3, 8'h55, 8'hAA, 1'b0, 1'b1, 8'h00, 4'h8};
    vecs[22] = '{4'h0, 1'b0, 2'd0, 8'h01, 8'h01, 1'b1, 1'b1, 8'h00, 4'h8};
    vecs[23] = '{4'hF, 1'b0, 2'd0, 8'h01, 8'h01, 1'b1, 1'b1, 8'h00, 4'h8};
    vecs[24] = '{4'h2, 1'b0, 2'd0, 8'hFF, 8'h01, 1'b1, 1'b0, 8'h00, 4'h8};

    rst             = 1'b1;
    bus.stall       = 1'b0;
    bus.flush       = 1'b0;
    bus.rd_in       = 2'd0;
    bus.wb_in       = 1'b0;
    bus.int_save    = 1'b0;
    bus.int_restore = 1'b0;
    drive(4'h2, 1'b0, 2'd0, 8'h11, 8'h22, 1'b1, 1'b1);
    step();
    step();
    chk("rst_valid",  32'(bus.ex_valid),   32'h0);
    chk("rst_result", 32'(bus.ex_result),  32'h0);
    chk("rst_ccr",    32'(bus.ccr),        32'h0);
    chk("rst_shadow", 32'(bus.ccr_shadow), 32'h0);
    rst = 1'b0;

    // Back-to-back entries, one per cycle.
    for (int i = 0; i < 25; i++) begin
      logic [1:0] rd;
      rd = 2'(i);
      drive(vecs[i].alu, vecs[i].se2, vecs[i].se3, vecs[i].a, vecs[i].b,
            vecs[i].fw, vecs[i].vld);
      bus.rd_in = rd;
      bus.wb_in = rd[0];
      step();
      chk($sformatf("v%0d_result", i), 32'(bus.ex_result), 32'(vecs[i].exp_res));
      chk($sformatf("v%0d_ccr", i),    32'(bus.ccr),       32'(vecs[i].exp_ccr));
      chk($sformatf("v%0d_valid", i),  32'(bus.ex_valid),  32'(vecs[i].vld));
      chk($sformatf("v%0d_rd", i),     32'(bus.ex_rd),     32'(rd));
      chk($sformatf("v%0d_wb", i),     32'(bus.ex_wb),     32'(rd[0]));
    end

    // Interrupt save / restore against a concurrent flag-updating ADD.
    drive(4'h3, 1'b0, 2'd0, 8'h00, 8'h01, 1'b1, 1'b1);
    step();
    chk("irq_pre_ccr", 32'(bus.ccr), 32'h6);
    drive(4'h0, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0);
    bus.int_save = 1'b1;
    step();
    bus.int_save = 1'b0;
    chk("irq_shadow", 32'(bus.ccr_shadow), 32'h6);
    drive(4'h9, 1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b1);
    step();
    chk("irq_clrc_ccr", 32'(bus.ccr), 32'h2);
    drive(4'h2, 1'b0, 2'd0, 8'h7F, 8'h01, 1'b1, 1'b1);
    bus.int_restore = 1'b1;
    step();
    bus.int_restore = 1'b0;
    chk("irq_restore_ccr",    32'(bus.ccr),       32'h6);
    chk("irq_restore_result", 32'(bus.ex_result), 32'h80);

    drive(4'h9, 1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b1);
    step();
    drive(4'h0, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0);
    bus.int_save = 1'b1;
    step();
    chk("irq_shadow2", 32'(bus.ccr_shadow), 32'h2);
    bus.int_save = 1'b0;
    drive(4'h8, 1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b1);
    step();
    chk("irq_setc_ccr", 32'(bus.ccr), 32'h6);
    drive(4'h0, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0);
    bus.int_save    = 1'b1;
    bus.int_restore = 1'b1;
    step();
    bus.int_save    = 1'b0;
    bus.int_restore = 1'b0;
    chk("irq_both_ccr",    32'(bus.ccr),        32'h2);
    chk("irq_both_shadow", 32'(bus.ccr_shadow), 32'h2);

    // Stall freezes everything for three cycles.
    drive(4'h2, 1'b0, 2'd0, 8'h10, 8'h01, 1'b0, 1'b1);
    bus.rd_in = 2'd2;
    bus.wb_in = 1'b1;
    step();
    chk("stl_pre_result", 32'(bus.ex_result), 32'h11);
    drive(4'h2, 1'b0, 2'd0, 8'h7F, 8'h01, 1'b1, 1'b1);
    bus.rd_in = 2'd1;
    bus.wb_in = 1'b0;
    bus.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("stl%0d_result", k), 32'(bus.ex_result), 32'h11);
      chk($sformatf("stl%0d_valid", k),  32'(bus.ex_valid),  32'h1);
      chk($sformatf("stl%0d_rd", k),     32'(bus.ex_rd),     32'h2);
      chk($sformatf("stl%0d_wb", k),     32'(bus.ex_wb),     32'h1);
      chk($sformatf("stl%0d_ccr", k),    32'(bus.ccr),       32'h2);
    end
    bus.stall = 1'b0;
    step();
    chk("stl_rel_result", 32'(bus.ex_result), 32'h80);
    chk("stl_rel_ccr",    32'(bus.ccr),       32'hA);
    chk("stl_rel_rd",     32'(bus.ex_rd),     32'h1);

    // Flush wins over stall and blocks the flag update.
    drive(4'h3, 1'b0, 2'd0, 8'h00, 8'h01, 1'b1, 1'b1);
    bus.wb_in = 1'b1;
    bus.stall = 1'b1;
    bus.flush = 1'b1;
    step();
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    chk("fl_valid", 32'(bus.ex_valid), 32'h0);
    chk("fl_wb",    32'(bus.ex_wb),    32'h0);
    chk("fl_ccr",   32'(bus.ccr),      32'hA);

    // Reset mid-stream discards the in-flight entry and clears the shadow.
    drive(4'h0, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0);
    bus.int_save = 1'b1;
    step();
    bus.int_save = 1'b0;
    chk("mr_pre_shadow", 32'(bus.ccr_shadow), 32'hA);
    drive(4'h2, 1'b0, 2'd0, 8'h7F, 8'h01, 1'b1, 1'b1);
    bus.rd_in    = 2'd3;
    bus.wb_in    = 1'b1;
    bus.int_save = 1'b1;
    rst          = 1'b1;
    step();
    rst          = 1'b0;
    bus.int_save = 1'b0;
    chk("mr_valid",  32'(bus.ex_valid),   32'h0);
    chk("mr_result", 32'(bus.ex_result),  32'h0);
    chk("mr_rd",     32'(bus.ex_rd),      32'h0);
    chk("mr_wb",     32'(bus.ex_wb),      32'h0);
    chk("mr_ccr",    32'(bus.ccr),        32'h0);
    chk("mr_shadow", 32'(bus.ccr_shadow), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have parameter DW, default 8, datapath width.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports in_valid  in  1 (ID/EX entry valid); stall  in  1 (hold stage); flush  in  1 (kill entry).
REQ-005 SHALL have ports alu_control  in  4; se2  in  1; se3  in  2 (decoder-supplied execute controls).
REQ-006 SHALL have ports op_a  in  DW (R[ra], SP or imm, already muxed); op_b  in  DW (R[rb]).
REQ-007 SHALL have ports flag_we  in  1 (allow CCR update); rd_in  in  2; wb_in  in  1.
REQ-008 SHALL have ports int_save  in  1 (interrupt entry); int_restore  in  1 (RTI in execute).
REQ-009 SHALL have ports ex_valid  out  1; ex_result  out  DW; ex_rd  out  2; ex_wb  out  1.
REQ-010 SHALL have ports ccr  out  4 ({V,C,N,Z}); ccr_shadow  out  4; all outputs registered.

Function
REQ-011 SHALL form operand B as op_b when se2=0, constant 1 when se2=1.
REQ-012 SHALL compute alu_res: 0010 A+B; 0011 A-B; 0100 A&B; 0101 A|B; 0110 RLC {B[DW-2:0],C}; 0111 RRC {C,B[DW-1:1]}.
REQ-013 SHALL compute 1010 ~B, 1011 0-B, 1100 B+1, 1101 B-1; 1000/1001 (SETC/CLRC), 0000 and unused codes give alu_res=0.
REQ-014 SHALL select stage result: se3=0 alu_res, se3=1 op_a, se3=2 op_b, se3=3 0.
REQ-015 SHALL latch result, rd_in, wb_in into ex_result/ex_rd/ex_wb, and ex_valid<=in_valid, on each non-stalled edge; latency exactly 1 cycle.
REQ-016 SHALL hold all outputs and CCR unchanged while stall=1 and flush=0.
REQ-017 SHALL on flush=1 set ex_valid=0, ex_wb=0 next edge, update no flags; flush overrides stall.
REQ-018 SHALL update CCR only when in_valid=1, flag_we=1, stall=0, flush=0, and only for non-NOP codes.
REQ-019 SHALL set Z=(alu_res==0), N=alu_res[DW-1] for ADD,SUB,AND,OR,RLC,RRC,NOT,NEG,INC,DEC.
REQ-020 SHALL set C: ADD/INC carry-out; SUB/DEC borrow (1 when minuend < subtrahend unsigned); NEG 1 iff B!=0; RLC old B[DW-1]; RRC old B[0]; SETC 1; CLRC 0.
REQ-021 SHALL set V: ADD/INC/SUB/DEC signed overflow; NEG 1 iff B==0x80 (DW=8, MSB-only pattern generally).
REQ-022 SHALL leave C and V unchanged for AND,OR,NOT; leave Z,N,V unchanged for SETC/CLRC.
REQ-023 SHALL use the registered (pre-edge) C as carry-in for RLC/RRC.
REQ-024 SHALL on int_save=1 copy current registered CCR into ccr_shadow, regardless of stall.
REQ-025 SHALL on int_restore=1 load CCR from ccr_shadow, overriding any same-cycle ALU flag update.
REQ-026 SHALL on int_save and int_restore together restore CCR from old shadow and leave shadow unchanged.
REQ-027 SHALL process back-to-back valid entries every cycle with no bubbles absent stall/flush.

Reset
REQ-028 SHALL on rst=1 at an edge clear ex_valid, ex_result, ex_rd, ex_wb, ccr, ccr_shadow to 0.
REQ-029 SHALL give rst priority over flush, stall, int_save, int_restore; an entry in flight during reset is discarded.

Verification
REQ-030 SHALL pass: ADD op_a=0x7F, op_b=0x01, se2=0, flag_we=1 -> next cycle ex_result=0x80, ccr V=1,C=0,N=1,Z=0.
REQ-031 SHALL pass: SETC then RLC op_b=0x80 -> ex_result=0x01, C=1, Z=0; then RRC op_b=0x00 -> ex_result=0x80, C=0, N=1.
REQ-032 SHALL pass: SUB op_a=0x03, se2=1 (LOOP) -> ex_result=0x02, C=0, Z=0; with op_a=0x01 -> 0x00, Z=1.
REQ-033 SHALL pass: ADD with se2=1, se3=0, flag_we=0 (POP) -> ex_result=op_a+1, ccr unchanged.
REQ-034 SHALL pass: CCR=0x6, int_save; CLRC; then int_restore with concurrent flag-updating ADD -> ccr=0x6.
REQ-035 SHALL pass: stall for 3 cycles mid-stream -> outputs frozen; flush with stall -> ex_valid=0 next cycle; rst mid-stream -> all outputs 0.
